// File: rtl/kws_requant.sv
// TFLM int8 requantization output stage behind the KWS MAC accumulator CFU.
// Config writes answer in one cycle; REQUANT runs a 4-stage pipeline with one command outstanding.
module kws_requant (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        rsp_payload_response_ok
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned Y_W    = 34;

    localparam logic [2:0] F_SET_MULT  = 3'd0;
    localparam logic [2:0] F_SET_SHIFT = 3'd1;
    localparam logic [2:0] F_SET_CLAMP = 3'd2;
    localparam logic [2:0] F_REQUANT   = 3'd3;

    localparam logic signed [DATA_W-1:0] INT32_MIN = 32'sh8000_0000;
    localparam logic signed [DATA_W-1:0] INT32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [PROD_W-1:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
    localparam logic signed [PROD_W-1:0] NUDGE_NEG = 64'shFFFF_FFFF_C000_0001;
    localparam logic signed [PROD_W-1:0] DIV_BIAS  = 64'sh0000_0000_7FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_payload_q, rsp_payload_d;

    logic signed [DATA_W-1:0] mult_q, mult_d;
    logic [4:0]               rshift_q, rshift_d;
    logic signed [8:0]        off_q, off_d;
    logic signed [7:0]        act_min_q, act_min_d;
    logic signed [7:0]        act_max_q, act_max_d;

    logic signed [DATA_W-1:0] x_q, x_d;
    logic signed [PROD_W-1:0] p_q, p_d;
    logic                     sat_q, sat_d;
    logic signed [DATA_W-1:0] h_q, h_d;

    logic [2:0] funct3_c;
    logic       accept_c;

    assign funct3_c = cmd_payload_function_id[2:0];
    assign accept_c = cmd_valid && cmd_ready_q;

    // S2: full-width product plus the single overflowing corner of the doubling high multiply
    assign p_d   = PROD_W'(x_q) * PROD_W'(mult_q);
    assign sat_d = (x_q == INT32_MIN) && (mult_q == INT32_MIN);

    // S3: round-to-nearest high half, division truncating toward zero
    logic signed [PROD_W-1:0] sum_c, quot_c;
    always_comb begin
        sum_c = p_q + (p_q[PROD_W-1] ? NUDGE_NEG : NUDGE_POS);
        if (sum_c[PROD_W-1]) begin
            quot_c = (sum_c + DIV_BIAS) >>> 31;
        end else begin
            quot_c = sum_c >>> 31;
        end
    end
    assign h_d = sat_q ? INT32_MAX : quot_c[DATA_W-1:0];

    // S4: rounding arithmetic shift, output offset and activation clamp
    logic [DATA_W-1:0]        mask_c, rem_c, thr_c;
    logic signed [DATA_W-1:0] sh_c, r_c;
    logic signed [Y_W-1:0]    y_c, lo_c, clamp_c, min_c, max_c;
    logic [31:0]              out_c;
    always_comb begin
        mask_c  = (32'd1 << rshift_q) - 32'd1;
        rem_c   = h_q & mask_c;
        thr_c   = (mask_c >> 1) + {31'd0, h_q[DATA_W-1]};
        sh_c    = h_q >>> rshift_q;
        r_c     = sh_c + {31'd0, (rem_c > thr_c)};
        y_c     = Y_W'(r_c) + Y_W'(off_q);
        min_c   = Y_W'(act_min_q);
        max_c   = Y_W'(act_max_q);
        lo_c    = (y_c > max_c) ? max_c : y_c;
        clamp_c = (lo_c < min_c) ? min_c : lo_c;
        out_c   = {{24{clamp_c[7]}}, clamp_c[7:0]};
    end

    // Next-state, config and response logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_payload_d = rsp_payload_q;
        mult_d        = mult_q;
        rshift_d      = rshift_q;
        off_d         = off_q;
        act_min_d     = act_min_q;
        act_max_d     = act_max_q;
        x_d           = x_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    cmd_ready_d = 1'b0;
                    if (funct3_c == F_REQUANT) begin
                        x_d     = cmd_payload_inputs_0 + cmd_payload_inputs_1;
                        cnt_d   = 2'd0;
                        state_d = ST_BUSY;
                    end else begin
                        unique case (funct3_c)
                            F_SET_MULT: mult_d = cmd_payload_inputs_0;
                            F_SET_SHIFT: begin
                                rshift_d = cmd_payload_inputs_0[4:0];
                                off_d    = cmd_payload_inputs_1[8:0];
                            end
                            F_SET_CLAMP: begin
                                act_min_d = cmd_payload_inputs_0[7:0];
                                act_max_d = cmd_payload_inputs_0[15:8];
                            end
                            default: ;
                        endcase
                        rsp_payload_d = 32'd0;
                        rsp_valid_d   = 1'b1;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd2) begin
                    rsp_payload_d = out_c;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 2'd0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_payload_q <= 32'd0;
            mult_q        <= INT32_MAX;
            rshift_q      <= 5'd0;
            off_q         <= 9'sd0;
            act_min_q     <= -8'sd128;
            act_max_q     <= 8'sd127;
            x_q           <= '0;
            p_q           <= '0;
            sat_q         <= 1'b0;
            h_q           <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_payload_q <= rsp_payload_d;
            mult_q        <= mult_d;
            rshift_q      <= rshift_d;
            off_q         <= off_d;
            act_min_q     <= act_min_d;
            act_max_q     <= act_max_d;
            x_q           <= x_d;
            p_q           <= p_d;
            sat_q         <= sat_d;
            h_q           <= h_d;
        end
    end

    assign cmd_ready               = cmd_ready_q;
    assign rsp_valid               = rsp_valid_q;
    assign rsp_payload_outputs_0   = rsp_payload_q;
    assign rsp_payload_response_ok = 1'b1;

    logic unused_c;
    assign unused_c = ^{cmd_payload_function_id[9:3], quot_c[PROD_W-1:DATA_W], clamp_c[Y_W-1:8]};

endmodule

// File: tb/tb_kws_requant.sv
// Directed bench for kws_requant: config commands, requant arithmetic corners, handshake and reset.
module tb_kws_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic        rsp_payload_response_ok;

    int checks = 0;
    int errors = 0;

    localparam logic [9:0] F_MULT  = 10'd0;
    localparam logic [9:0] F_SHIFT = 10'd1;
    localparam logic [9:0] F_CLAMP = 10'd2;
    localparam logic [9:0] F_REQ   = 10'd3;

    always #5 clk = ~clk;

    kws_requant dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .rsp_payload_response_ok (rsp_payload_response_ok)
    );

    task automatic accept_cmd(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        cmd_payload_function_id = fid;
        cmd_payload_inputs_0    = a;
        cmd_payload_inputs_1    = b;
        cmd_valid               = 1'b1;
        @(posedge clk); #1;
        cmd_valid               = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat);
        accept_cmd(fid, a, b);
        wait_rsp(lat);
        res = rsp_payload_outputs_0;
        consume();
    endtask

    task automatic test_reset();
        logic [31:0] res;
        int lat;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_payload_outputs_0 !== 32'h0) begin errors++; $display("FAIL reset_payload: got %h expected 00000000", rsp_payload_outputs_0); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (rsp_payload_response_ok !== 1'b1) begin errors++; $display("FAIL response_ok: got %b expected 1", rsp_payload_response_ok); end
        reset = 1'b0;
        run_cmd(F_REQ, 32'd100, 32'd0, res, lat);
        checks++; if (res !== 32'h0000_0064) begin errors++; $display("FAIL default_requant: got %h expected 00000064", res); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL requant_latency: got %0d expected 4", lat); end
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL post_consume: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, cmd_ready); end
        checks++; if (rsp_payload_outputs_0 !== 32'h0000_0064) begin errors++; $display("FAIL payload_hold: got %h expected 00000064", rsp_payload_outputs_0); end
    endtask

    task automatic test_half_mult();
        logic [31:0] res;
        int lat;
        run_cmd(F_MULT, 32'h4000_0000, 32'd0, res, lat);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL set_mult_result: got %h expected 00000000", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL config_latency: got %0d expected 1", lat); end
        run_cmd(F_SHIFT, 32'd0, 32'h0000_0180, res, lat);
        run_cmd(F_REQ, 32'd100, 32'd0, res, lat);
        checks++; if (res !== 32'hFFFF_FFB2) begin errors++; $display("FAIL half_mult_offset: got %h expected ffffffb2", res); end
        run_cmd(F_SHIFT, 32'd0, 32'd0, res, lat);
        run_cmd(F_REQ, 32'hFFFF_FFFB, 32'd0, res, lat);
        checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL half_mult_negative: got %h expected fffffffe", res); end
        run_cmd(F_REQ, 32'd90, 32'd10, res, lat);
        checks++; if (res !== 32'h0000_0032) begin errors++; $display("FAIL half_mult_bias: got %h expected 00000032", res); end
    endtask

    task automatic test_rounding();
        logic [31:0] res;
        int lat;
        run_cmd(F_MULT, 32'h7FFF_FFFF, 32'd0, res, lat);
        run_cmd(F_SHIFT, 32'd1, 32'd10, res, lat);
        run_cmd(F_REQ, 32'd3, 32'd0, res, lat);
        checks++; if (res !== 32'h0000_000C) begin errors++; $display("FAIL round_pos_offset: got %h expected 0000000c", res); end
        run_cmd(F_SHIFT, 32'd1, 32'd0, res, lat);
        run_cmd(F_REQ, 32'hFFFF_FFFD, 32'd0, res, lat);
        checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL round_neg_half: got %h expected fffffffe", res); end
        run_cmd(F_REQ, 32'd5, 32'd0, res, lat);
        checks++; if (res !== 32'h0000_0003) begin errors++; $display("FAIL round_pos_half: got %h expected 00000003", res); end
    endtask

    task automatic test_saturation();
        logic [31:0] res;
        int lat;
        run_cmd(F_MULT, 32'h8000_0000, 32'd0, res, lat);
        run_cmd(F_CLAMP, 32'h0000_7F80, 32'd0, res, lat);
        run_cmd(F_REQ, 32'h8000_0000, 32'd0, res, lat);
        checks++; if (res !== 32'h0000_007F) begin errors++; $display("FAIL sat_min_min: got %h expected 0000007f", res); end
        run_cmd(F_REQ, 32'h7FFF_FFFF, 32'd1, res, lat);
        checks++; if (res !== 32'h0000_007F) begin errors++; $display("FAIL sat_wrap_bias: got %h expected 0000007f", res); end
    endtask

    task automatic test_clamp();
        logic [31:0] res;
        int lat;
        run_cmd(F_MULT, 32'h7FFF_FFFF, 32'd0, res, lat);
        run_cmd(F_SHIFT, 32'd0, 32'd0, res, lat);
        run_cmd(F_CLAMP, 32'h0000_0AF6, 32'd0, res, lat);
        run_cmd(F_REQ, 32'd50, 32'd0, res, lat);
        checks++; if (res !== 32'h0000_000A) begin errors++; $display("FAIL clamp_max: got %h expected 0000000a", res); end
        run_cmd(F_REQ, 32'hFFFF_FFCE, 32'd0, res, lat);
        checks++; if (res !== 32'hFFFF_FFF6) begin errors++; $display("FAIL clamp_min: got %h expected fffffff6", res); end
        run_cmd(F_CLAMP, 32'h0000_FB05, 32'd0, res, lat);
        run_cmd(F_REQ, 32'd0, 32'd0, res, lat);
        checks++; if (res !== 32'h0000_0005) begin errors++; $display("FAIL clamp_min_wins: got %h expected 00000005", res); end
        run_cmd(F_CLAMP, 32'h0000_7F80, 32'd0, res, lat);
        run_cmd(F_SHIFT, 32'd0, 32'h0000_00FF, res, lat);
        run_cmd(F_REQ, 32'd100, 32'd0, res, lat);
        checks++; if (res !== 32'h0000_007F) begin errors++; $display("FAIL offset_max_clamp: got %h expected 0000007f", res); end
        run_cmd(F_SHIFT, 32'd0, 32'h0000_0100, res, lat);
        run_cmd(F_REQ, 32'd100, 32'd0, res, lat);
        checks++; if (res !== 32'hFFFF_FF80) begin errors++; $display("FAIL offset_min_clamp: got %h expected ffffff80", res); end
        run_cmd(F_SHIFT, 32'd0, 32'd0, res, lat);
    endtask

    task automatic test_stall();
        logic [31:0] res;
        int lat;
        logic bad;
        rsp_ready = 1'b0;
        accept_cmd(F_REQ, 32'd7, 32'd0);
        wait_rsp(lat);
        checks++; if (lat !== 4 || rsp_payload_outputs_0 !== 32'h7) begin errors++; $display("FAIL stall_first: got lat=%0d data=%h expected lat=4 data=00000007", lat, rsp_payload_outputs_0); end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_payload_outputs_0 !== 32'h7 || cmd_ready !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stall_stable: got valid=%b data=%h ready=%b expected 1/00000007/0", rsp_valid, rsp_payload_outputs_0, cmd_ready); end
        consume();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", rsp_valid); end
        run_cmd(10'd6, 32'h1234_5678, 32'hFFFF_FFFF, res, lat);
        checks++; if (res !== 32'h0 || lat !== 1) begin errors++; $display("FAIL unknown_cmd: got data=%h lat=%0d expected 00000000 lat=1", res, lat); end
        run_cmd({7'h7F, 3'd3}, 32'd7, 32'd0, res, lat);
        checks++; if (res !== 32'h0000_0007) begin errors++; $display("FAIL no_config_change: got %h expected 00000007", res); end
    endtask

    task automatic test_back_to_back();
        int acc_n = 0;
        int rsp_n = 0;
        int lat;
        rsp_ready               = 1'b1;
        cmd_payload_function_id = F_REQ;
        cmd_payload_inputs_0    = 32'd1;
        cmd_payload_inputs_1    = 32'd0;
        cmd_valid               = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (cmd_ready === 1'b1) acc_n++;
            if (rsp_valid === 1'b1) rsp_n++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        checks++; if (acc_n !== 3 || rsp_n !== 2) begin errors++; $display("FAIL b2b_throughput: got accepts=%0d rsps=%0d expected 3/2", acc_n, rsp_n); end
        wait_rsp(lat);
        checks++; if (rsp_payload_outputs_0 !== 32'h1) begin errors++; $display("FAIL b2b_data: got %h expected 00000001", rsp_payload_outputs_0); end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat;
        logic seen;
        run_cmd(F_MULT, 32'h4000_0000, 32'd0, res, lat);
        accept_cmd(F_REQ, 32'd100, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL midreset_state: got valid=%b ready=%b expected 0/1", rsp_valid, cmd_ready); end
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_discard: got rsp_valid=1 expected none"); end
        run_cmd(F_REQ, 32'd100, 32'd0, res, lat);
        checks++; if (res !== 32'h0000_0064 || lat !== 4) begin errors++; $display("FAIL midreset_defaults: got %h lat=%0d expected 00000064 lat=4", res, lat); end
    endtask

    initial begin
        reset                   = 1'b1;
        cmd_valid               = 1'b0;
        rsp_ready               = 1'b0;
        cmd_payload_function_id = 10'd0;
        cmd_payload_inputs_0    = 32'd0;
        cmd_payload_inputs_1    = 32'd0;
        #1;
        test_reset();
        test_half_mult();
        test_rounding();
        test_saturation();
        test_clamp();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
